color_sequencer: RTL

Run/pause/step controller for the color-cycling display path. It replaces the free-running divided clock with a single-clock tick-enable scheme. An internal prescaler times dwell per color, and a 3-state FSM sequences a six-entry color table. The selected color drives PWM-dimmed RGB LED outputs, all in the `clk` domain.

---
 rtl/color_pkg.sv | 43 ++++
 rtl/color_sequencer_tick_gen.sv | 46 ++++
 rtl/color_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/color_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : color_pkg
//  Description : Shared definitions for the colour sequencer: FSM state
//                encoding, colour-table size, colour index constants and
//                the index -> {r,g,b} lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package color_pkg;

    // FSM states; encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int NUM_COLORS = 6;

    localparam logic [2:0] IDX_RED     = 3'd0;
    localparam logic [2:0] IDX_YELLOW  = 3'd1;
    localparam logic [2:0] IDX_GREEN   = 3'd2;
    localparam logic [2:0] IDX_CYAN    = 3'd3;
    localparam logic [2:0] IDX_BLUE    = 3'd4;
    localparam logic [2:0] IDX_MAGENTA = 3'd5;

    // Colour table, result is {r,g,b}. Out-of-range indices give black.
    function automatic logic [2:0] color_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            IDX_RED:     rgb = 3'b100;
            IDX_YELLOW:  rgb = 3'b110;
            IDX_GREEN:   rgb = 3'b010;
            IDX_CYAN:    rgb = 3'b011;
            IDX_BLUE:    rgb = 3'b001;
            IDX_MAGENTA: rgb = 3'b101;
            default:     rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/color_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler producing a single-cycle tick enable every DIV
//                enabled cycles. Count holds while en is low.
//  Ports       : clk   - system clock
//                rst_n - synchronous active-low reset (count -> 0)
//                en    - count enable
//                tick  - high while enabled and count == DIV-1
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Explicit wrap so non-power-of-two DIV values work.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/color_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : color_sequencer
//  Description : Run/pause/step controller cycling a six-entry colour table
//                with PWM-dimmed RGB outputs, single clock domain.
//  Ports       : clk       - system clock
//                rst_n     - synchronous active-low reset
//                run       - 1 = auto-advance, 0 = pause
//                step      - single-cycle manual advance (paused only)
//                dir       - 0 = forward, 1 = reverse
//                bright    - PWM duty for lit channels
//                color_idx - current colour index 0..5
//                rgb       - {r,g,b} PWM drive
//                adv       - pulse in the cycle color_idx changes
//                state     - FSM state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module color_sequencer
    import color_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int STEP_HZ  = 1,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic                dir,
    input  logic [PWM_BITS-1:0] bright,
    output logic [2:0]          color_idx,
    output logic [2:0]          rgb,
    output logic                adv,
    output logic [1:0]          state
);

    localparam int DIV = CLK_HZ / STEP_HZ;

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                adv_q;
    logic [2:0]          rgb_q, rgb_d;
    logic [PWM_BITS-1:0] pwm_q;

    logic advance;
    logic tick;
    logic presc_rst_n;
    logic presc_en;

    // The prescaler is cleared throughout IDLE so the first dwell after
    // leaving IDLE is a full DIV cycles; in PAUSE it simply stops counting.
    assign presc_rst_n = rst_n && (state_q != ST_IDLE);
    assign presc_en    = (state_q == ST_RUN);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (presc_rst_n),
        .en    (presc_en),
        .tick  (tick)
    );

    // Next-state and advance decision.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_PAUSE;
                    advance = 1'b1;
                end
            end
            ST_RUN: begin
                advance = tick;
                if (!run) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                // run wins over a coincident step; the step is dropped.
                if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Modulo-6 index update computed directly, never passing through 6/7.
    always_comb begin
        idx_d = idx_q;
        if (advance) begin
            if (dir) begin
                idx_d = (idx_q == IDX_RED) ? IDX_MAGENTA : idx_q - 3'd1;
            end else begin
                idx_d = (idx_q == IDX_MAGENTA) ? IDX_RED : idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        rgb_d = 3'b000;
        if ((state_q != ST_IDLE) && (pwm_q < bright)) begin
            rgb_d = color_rgb(idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_RED;
            adv_q   <= 1'b0;
            rgb_q   <= 3'b000;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            adv_q   <= advance;
            rgb_q   <= rgb_d;
            pwm_q   <= pwm_q + PWM_BITS'(1);
        end
    end

    assign color_idx = idx_q;
    assign rgb       = rgb_q;
    assign adv       = adv_q;
    assign state     = state_q;

endmodule
`default_nettype wire
